// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the integer register file: primary pipeline writeback plus a FIFO-buffered
// long-latency secondary source. Optional same-cycle secondary bypass when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter #(
    parameter int REG_SIZE   = 32,
    parameter int REGW       = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pri_we_i,
    input  logic [REGW-1:0]          pri_waddr_i,
    input  logic [REG_SIZE-1:0]      pri_wdata_i,
    output logic                     pri_stall_o,
    input  logic                     sec_valid_i,
    output logic                     sec_ready_o,
    input  logic [REGW-1:0]          sec_waddr_i,
    input  logic [REG_SIZE-1:0]      sec_wdata_i,
    output logic                     rf_we_o,
    output logic [REGW-1:0]          rf_waddr_o,
    output logic [REG_SIZE-1:0]      rf_wdata_o,
    input  logic [REGW-1:0]          raddr1_i,
    input  logic [REGW-1:0]          raddr2_i,
    output logic                     pend1_o,
    output logic                     pend2_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PRI,
        SRC_FIFO,
        SRC_BYP
    } src_t;

    logic [REGW-1:0]     mem_addr [DEPTH];
    logic [REG_SIZE-1:0] mem_data [DEPTH];
    logic [PTRW-1:0]     rd_ptr;
    logic [PTRW-1:0]     wr_ptr;
    logic [CNTW-1:0]     count;
    logic [SW-1:0]       starve_cnt;

    logic                pri_valid;
    logic                fifo_empty;
    logic                forced;
    logic                bypass;
    logic                push;
    logic                pop;
    src_t                src;
    logic [PTRW-1:0]     scan_idx;

    assign pri_valid   = pri_we_i && (pri_waddr_i != '0);
    assign fifo_empty  = (count == '0);
    assign forced      = (starve_cnt == SW'(STARVE_MAX)) && !fifo_empty;
    assign sec_ready_o = (count < CNTW'(DEPTH));
    assign fifo_cnt_o  = count;
    assign pri_stall_o = forced && pri_valid;

`ifdef RF_WB_BYPASS_EN
    // An idle port with nothing queued lets the secondary write straight through.
    assign bypass = fifo_empty && !pri_valid && sec_valid_i && (sec_waddr_i != '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        src = SRC_NONE;
        if (forced) begin
            src = SRC_FIFO;
        end else if (pri_valid) begin
            src = SRC_PRI;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (bypass) begin
            src = SRC_BYP;
        end
    end

    assign pop  = (src == SRC_FIFO);
    assign push = sec_valid_i && sec_ready_o && (sec_waddr_i != '0) && !bypass;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        case (src)
            SRC_PRI: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = pri_waddr_i;
                rf_wdata_o = pri_wdata_i;
            end
            SRC_FIFO: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = mem_addr[rd_ptr];
                rf_wdata_o = mem_data[rd_ptr];
            end
            SRC_BYP: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = sec_waddr_i;
                rf_wdata_o = sec_wdata_i;
            end
            default: begin
                rf_we_o    = 1'b0;
            end
        endcase
    end

    // The entry being popped still counts as pending: its data only lands after this edge.
    always_comb begin
        pend1_o  = 1'b0;
        pend2_o  = 1'b0;
        scan_idx = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PTRW'(i);
            if (CNTW'(i) < count) begin
                if ((raddr1_i != '0) && (mem_addr[scan_idx] == raddr1_i)) begin
                    pend1_o = 1'b1;
                end
                if ((raddr2_i != '0) && (mem_addr[scan_idx] == raddr2_i)) begin
                    pend2_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_addr[wr_ptr] <= sec_waddr_i;
            mem_data[wr_ptr] <= sec_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Counts only cycles where queued work was passed over in favour of the primary.
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if ((src == SRC_PRI) && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based reference model predicts each cycle's outputs,
// a monitor compares them at the falling edge. Honours RF_WB_BYPASS_EN when defined.
module tb_rf_wb_arbiter;

    localparam int REG_SIZE   = 32;
    localparam int REGW       = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int CNTW       = $clog2(DEPTH) + 1;

    logic                clk;
    logic                rst_i;
    logic                pri_we_i;
    logic [REGW-1:0]     pri_waddr_i;
    logic [REG_SIZE-1:0] pri_wdata_i;
    logic                pri_stall_o;
    logic                sec_valid_i;
    logic                sec_ready_o;
    logic [REGW-1:0]     sec_waddr_i;
    logic [REG_SIZE-1:0] sec_wdata_i;
    logic                rf_we_o;
    logic [REGW-1:0]     rf_waddr_o;
    logic [REG_SIZE-1:0] rf_wdata_o;
    logic [REGW-1:0]     raddr1_i;
    logic [REGW-1:0]     raddr2_i;
    logic                pend1_o;
    logic                pend2_o;
    logic [CNTW-1:0]     fifo_cnt_o;

    rf_wb_arbiter #(
        .REG_SIZE(REG_SIZE), .REGW(REGW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pri_we_i(pri_we_i), .pri_waddr_i(pri_waddr_i), .pri_wdata_i(pri_wdata_i),
        .pri_stall_o(pri_stall_o),
        .sec_valid_i(sec_valid_i), .sec_ready_o(sec_ready_o),
        .sec_waddr_i(sec_waddr_i), .sec_wdata_i(sec_wdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
        .pend1_o(pend1_o), .pend2_o(pend2_o), .fifo_cnt_o(fifo_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [REGW-1:0]     addr;
        logic [REG_SIZE-1:0] data;
    } entry_t;

    typedef struct {
        logic                we;
        logic [REGW-1:0]     waddr;
        logic [REG_SIZE-1:0] wdata;
        logic                stall;
        logic                ready;
        logic                pend1;
        logic                pend2;
        logic [CNTW-1:0]     cnt;
    } status_t;

    entry_t  model_q[$];
    status_t exp_q[$];
    int      starve = 0;
    int      tests  = 0;
    int      errors = 0;
    int      cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs from the queue model, then advance the model.
    task automatic applyStimulus(input logic rst, input logic pwe, input logic [REGW-1:0] pa,
                                 input logic [REG_SIZE-1:0] pd, input logic sv,
                                 input logic [REGW-1:0] sa, input logic [REG_SIZE-1:0] sd,
                                 input logic [REGW-1:0] r1, input logic [REGW-1:0] r2);
        status_t e;
        int      sz;
        bit      pri_v, frc, byp, do_pop, do_push;
        entry_t  ne;
        @(posedge clk);
        #1;
        rst_i = rst; pri_we_i = pwe; pri_waddr_i = pa; pri_wdata_i = pd;
        sec_valid_i = sv; sec_waddr_i = sa; sec_wdata_i = sd;
        raddr1_i = r1; raddr2_i = r2;
        if (rst) begin
            model_q.delete();
            starve = 0;
            return;
        end
        sz     = model_q.size();
        pri_v  = pwe && (pa != 0);
        frc    = (starve == STARVE_MAX) && (sz > 0);
        byp    = 1'b0;
`ifdef RF_WB_BYPASS_EN
        byp    = (sz == 0) && !pri_v && sv && (sa != 0);
`endif
        do_pop = 1'b0;
        e.we = 1'b0; e.waddr = '0; e.wdata = '0;
        if (frc || (!pri_v && sz > 0)) begin
            e.we = 1'b1; e.waddr = model_q[0].addr; e.wdata = model_q[0].data;
            do_pop = 1'b1;
        end else if (pri_v) begin
            e.we = 1'b1; e.waddr = pa; e.wdata = pd;
        end else if (byp) begin
            e.we = 1'b1; e.waddr = sa; e.wdata = sd;
        end
        e.stall = frc && pri_v;
        e.ready = (sz < DEPTH);
        e.pend1 = 1'b0;
        e.pend2 = 1'b0;
        foreach (model_q[i]) begin
            if (r1 != 0 && model_q[i].addr == r1) e.pend1 = 1'b1;
            if (r2 != 0 && model_q[i].addr == r2) e.pend2 = 1'b1;
        end
        e.cnt = CNTW'(sz);
        exp_q.push_back(e);
        do_push = sv && e.ready && (sa != 0) && !byp;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            ne.addr = sa; ne.data = sd;
            model_q.push_back(ne);
        end
        if (do_pop || sz == 0) starve = 0;
        else if (pri_v && starve < STARVE_MAX) starve++;
    endtask

    task automatic idle(input logic [REGW-1:0] r1, input logic [REGW-1:0] r2);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
    endtask

    initial begin
        status_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rf_we_o",     32'(rf_we_o),     32'(e.we));
                checkOutput("rf_waddr_o",  32'(rf_waddr_o),  32'(e.waddr));
                checkOutput("rf_wdata_o",  32'(rf_wdata_o),  32'(e.wdata));
                checkOutput("pri_stall_o", 32'(pri_stall_o), 32'(e.stall));
                checkOutput("sec_ready_o", 32'(sec_ready_o), 32'(e.ready));
                checkOutput("pend1_o",     32'(pend1_o),     32'(e.pend1));
                checkOutput("pend2_o",     32'(pend2_o),     32'(e.pend2));
                checkOutput("fifo_cnt_o",  32'(fifo_cnt_o),  32'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1; pri_we_i = 1'b0; pri_waddr_i = '0; pri_wdata_i = '0;
        sec_valid_i = 1'b0; sec_waddr_i = '0; sec_wdata_i = '0;
        raddr1_i = '0; raddr2_i = '0;

        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5'd3, 5'd0);
        idle(5'd0, 5'd7);

        // Single secondary write to x5, watched through the read-address hazard flag.
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        idle(5'd5, 5'd5);
        idle(5'd5, 5'd0);

        // Primary busy every cycle while x1..x4 fill the FIFO, then starvation forces x1 out.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b1, 5'd20 + 5'(i), $urandom, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'd2);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1'b1, 5'd10 + 5'(i), $urandom, 1'b0, 0, 0, 5'd1, 5'd4);

        // Full FIFO drained with the primary idle and the secondary held valid.
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b1, 5'd30, $urandom, 1'b1, 5'(i), 32'h200 + 32'(i), 0, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 5'd9, 32'h900 + 32'(i), 5'd9, 5'd1);
        for (int i = 0; i < 6; i++) idle(5'd9, 5'd0);

        // Writes aimed at x0 from both sources are dropped.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h1111, 1'b0, 0, 0, 0, 0);
        idle(0, 0);

        // Reset while three entries wait and a fourth is offered.
        for (int i = 1; i <= 3; i++)
            applyStimulus(1'b0, 1'b1, 5'd31, $urandom, 1'b1, 5'(i + 4), $urandom, 0, 0);
        applyStimulus(1'b1, 1'b1, 5'd31, 0, 1'b1, 5'd8, 32'hABCD, 5'd5, 5'd6);
        idle(5'd5, 5'd6);
        idle(5'd8, 5'd7);

        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                          5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 6),
                          5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 200; i++)
            applyStimulus(1'b0, ($urandom_range(0, 9) != 0),
                          5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 7),
                          5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
